// File: rtl/adc_if_pkg.sv
// Shared definitions for the ADC capture path: IDELAY tap defaults, training
// patterns and the calibration state encoding.
package adc_if_pkg;

  localparam int TAP_W_DFLT    = 5;
  localparam int NUM_TAPS_DFLT = 32;

  localparam logic [7:0] PATTERN_P_DFLT = 8'h55;
  localparam logic [7:0] PATTERN_N_DFLT = 8'hAA;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_EVAL,
    ST_CENTER,
    ST_VERIFY,
    ST_NEXT_LANE,
    ST_DONE
  } cal_state_e;

endpackage

// File: rtl/adc_idelay_calib_eye.sv
// Eye bookkeeping for one lane sweep: tracks the current passing run and the
// widest run seen so far, and derives the centre tap of that widest run.
module adc_eye_tracker
  import adc_if_pkg::*;
#(
  parameter int TAP_W   = TAP_W_DFLT,
  parameter int MIN_EYE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             eval,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W:0]   best_len,
  output logic [TAP_W-1:0] ctr
);

  logic [TAP_W:0]   run_q, run_d, best_len_q, best_len_d, run_inc, half;
  logic [TAP_W-1:0] best_start_q, best_start_d;

  always_comb begin
    run_inc      = run_q + 1'b1;
    run_d        = run_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    if (clear) begin
      run_d        = '0;
      best_len_d   = '0;
      best_start_d = '0;
    end else if (eval) begin
      if (pass) begin
        run_d = run_inc;
        // Strict compare keeps the lowest-tap eye when widths tie.
        if (run_inc > best_len_q) begin
          best_len_d   = run_inc;
          best_start_d = TAP_W'({1'b0, tap} - run_q);
        end
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q        <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else begin
      run_q        <= run_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
    end
  end

  always_comb begin
    half = (best_len_q - 1'b1) >> 1;
    ctr  = '0;
    if (best_len_q >= (TAP_W+1)'(MIN_EYE))
      ctr = best_start_q + half[TAP_W-1:0];
  end

  assign best_len = best_len_q;

endmodule

// File: rtl/adc_idelay_calib.sv
// Per-lane IDELAY calibration: sweeps every tap on each lane against a fixed
// ADC test pattern, loads the centre of the widest eye and reads it back.
module adc_idelay_calib
  import adc_if_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int TAP_W      = TAP_W_DFLT,
  parameter int NUM_TAPS   = NUM_TAPS_DFLT,
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 256,
  parameter int MIN_EYE    = 4,
  parameter logic [NUM_LANES-1:0] PATTERN_P = NUM_LANES'(PATTERN_P_DFLT),
  parameter logic [NUM_LANES-1:0] PATTERN_N = NUM_LANES'(PATTERN_N_DFLT)
) (
  input  logic                       adc_dco_clk,
  input  logic                       adc_rst_n,
  input  logic                       cal_start,
  input  logic [NUM_LANES-1:0]       adc_data_p_s,
  input  logic [NUM_LANES-1:0]       adc_data_n_s,
  input  logic [NUM_LANES*TAP_W-1:0] delay_rdata,
  output logic [NUM_LANES-1:0]       delay_ld,
  output logic [TAP_W-1:0]           delay_wdata,
  output logic                       cal_busy,
  output logic                       cal_done,
  output logic [NUM_LANES-1:0]       cal_fail,
  output logic [NUM_LANES*TAP_W-1:0] lane_tap
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int WIN_W  = $clog2(WINDOW_CYC + 1);

  cal_state_e               state_q, state_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [TAP_W-1:0]         tap_q, tap_d;
  logic [SET_W-1:0]         scnt_q, scnt_d;
  logic [WIN_W-1:0]         wcnt_q, wcnt_d;
  logic                     err_q, err_d, vfy_q, vfy_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic [NUM_LANES-1:0]     fail_q, fail_d;
  logic [NUM_LANES*TAP_W-1:0] lane_tap_q, lane_tap_d;

  logic             trk_clear, trk_eval, lane_err;
  logic [TAP_W:0]   best_len;
  logic [TAP_W-1:0] ctr, rdata_lane;

  adc_eye_tracker #(.TAP_W(TAP_W), .MIN_EYE(MIN_EYE)) u_eye (
    .clk      (adc_dco_clk),
    .rst_n    (adc_rst_n),
    .clear    (trk_clear),
    .eval     (trk_eval),
    .pass     (~err_q),
    .tap      (tap_q),
    .best_len (best_len),
    .ctr      (ctr)
  );

  assign lane_err   = (adc_data_p_s[lane_q] != PATTERN_P[lane_q]) ||
                      (adc_data_n_s[lane_q] != PATTERN_N[lane_q]);
  assign rdata_lane = delay_rdata[lane_q*TAP_W +: TAP_W];

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    tap_d       = tap_q;
    scnt_d      = scnt_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    vfy_d       = vfy_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    lane_tap_d  = lane_tap_q;
    trk_clear   = 1'b0;
    trk_eval    = 1'b0;
    delay_ld    = '0;
    delay_wdata = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cal_start) begin
          done_d     = 1'b0;
          fail_d     = '0;
          lane_tap_d = '0;
          lane_d     = '0;
          tap_d      = '0;
          err_d      = 1'b0;
          vfy_d      = 1'b0;
          busy_d     = 1'b1;
          trk_clear  = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        delay_ld[lane_q] = 1'b1;
        delay_wdata      = tap_q;
        scnt_d           = '0;
        state_d          = ST_SETTLE;
      end
      ST_SETTLE: begin
        scnt_d = scnt_q + 1'b1;
        if (scnt_q == SET_W'(SETTLE_CYC - 1)) begin
          wcnt_d  = '0;
          err_d   = 1'b0;
          state_d = vfy_q ? ST_VERIFY : ST_CHECK;
        end
      end
      ST_CHECK: begin
        err_d  = err_q | lane_err;
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WIN_W'(WINDOW_CYC - 1))
          state_d = ST_EVAL;
      end
      ST_EVAL: begin
        trk_eval = 1'b1;
        err_d    = 1'b0;
        if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
          state_d = ST_CENTER;
        end else begin
          tap_d   = tap_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_CENTER: begin
        // ctr is already 0 when the eye is too narrow.
        delay_ld[lane_q] = 1'b1;
        delay_wdata      = ctr;
        lane_tap_d[lane_q*TAP_W +: TAP_W] = ctr;
        if (best_len < (TAP_W+1)'(MIN_EYE))
          fail_d[lane_q] = 1'b1;
        vfy_d   = 1'b1;
        scnt_d  = '0;
        state_d = ST_SETTLE;
      end
      ST_VERIFY: begin
        if (rdata_lane != ctr)
          fail_d[lane_q] = 1'b1;
        state_d = ST_NEXT_LANE;
      end
      ST_NEXT_LANE: begin
        trk_clear = 1'b1;
        tap_d     = '0;
        vfy_d     = 1'b0;
        if (lane_q == LANE_W'(NUM_LANES - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          lane_d  = lane_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge adc_dco_clk) begin
    if (!adc_rst_n) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      tap_q      <= '0;
      scnt_q     <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      vfy_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= '0;
      lane_tap_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      tap_q      <= tap_d;
      scnt_q     <= scnt_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      vfy_q      <= vfy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      lane_tap_q <= lane_tap_d;
    end
  end

  assign cal_busy = busy_q;
  assign cal_done = done_q;
  assign cal_fail = fail_q;
  assign lane_tap = lane_tap_q;

endmodule

// File: tb/tb_adc_idelay_calib.sv
// Bench for adc_idelay_calib: IDELAY/ADC lane model driven by per-lane pass
// masks, with a scoreboard of expected tap loads and final calibration results.
module tb_adc_idelay_calib;
  localparam int NL = 8, TW = 5, NT = 32, SC = 3, WC = 6, ME = 4;
  localparam int LAT = NL * (NT * (SC + WC + 2) + SC + 3);

  logic clk = 1'b0, rst_n = 1'b0, cal_start = 1'b0;
  logic [NL-1:0] dp, dn, ld, fail;
  logic [NL*TW-1:0] rdata, lane_tap;
  logic [TW-1:0] wdata;
  logic busy, done;

  adc_idelay_calib #(.NUM_LANES(NL), .TAP_W(TW), .NUM_TAPS(NT), .SETTLE_CYC(SC),
                     .WINDOW_CYC(WC), .MIN_EYE(ME)) dut (
    .adc_dco_clk(clk), .adc_rst_n(rst_n), .cal_start(cal_start),
    .adc_data_p_s(dp), .adc_data_n_s(dn), .delay_rdata(rdata),
    .delay_ld(ld), .delay_wdata(wdata), .cal_busy(busy), .cal_done(done),
    .cal_fail(fail), .lane_tap(lane_tap));

  always #5 clk = ~clk;

  typedef struct { logic [NL*TW-1:0] tap; logic [NL-1:0] fail; } res_t;
  typedef struct { logic [NL-1:0] ld; logic [TW-1:0] wd; } ld_t;
  res_t exp_q[$];
  ld_t  ld_q[$];

  int n_cmp = 0, n_bad = 0, cyc = 0, start_cyc = 0;
  logic [NT-1:0] mask [NL];
  logic [TW-1:0] cur_tap [NL];
  logic [TW-1:0] rb_off [NL];
  logic [NL-1:0] pat_p = 8'h55, pat_n = 8'hAA;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always_comb
    for (int l = 0; l < NL; l++) rdata[l*TW +: TW] = cur_tap[l] + rb_off[l];

  // IDELAY + ADC model: failing taps corrupt the lane on even cycles only.
  always @(negedge clk) begin : lane_model
    logic good;
    for (int l = 0; l < NL; l++) if (ld[l]) cur_tap[l] = wdata;
    for (int l = 0; l < NL; l++) begin
      good  = mask[l][cur_tap[l]];
      dp[l] = pat_p[l] ^ (!good && (cyc % 2 == 0) && cur_tap[l][0]);
      dn[l] = pat_n[l] ^ (!good && (cyc % 2 == 0) && !cur_tap[l][0]);
    end
  end

  // Monitor: pops expected loads and final results as the DUT presents them.
  logic prev_done = 1'b0;
  always @(negedge clk) begin : monitor
    ld_t e;
    res_t r;
    if (ld != '0) begin
      if (ld_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_load: got ld=%0h wdata=%0d want none", ld, wdata);
      end else begin
        e = ld_q.pop_front();
        chk("load_ld", 64'(ld), 64'(e.ld));
        chk("load_wdata", 64'(wdata), 64'(e.wd));
      end
    end
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got cal_done=1 want 0");
      end else begin
        r = exp_q.pop_front();
        chk("lane_tap", 64'(lane_tap), 64'(r.tap));
        chk("cal_fail", 64'(fail), 64'(r.fail));
        chk("latency", 64'(cyc - start_cyc), 64'(LAT));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
    prev_done = done;
  end

  // Reference: enumerate maximal passing intervals, first widest wins.
  function automatic void ref_lane(input logic [NT-1:0] m, output logic [TW-1:0] c,
                                   output logic ef);
    int bl, bs, e;
    bl = 0; bs = 0;
    for (int s = 0; s < NT; s++) begin
      if (m[s] && (s == 0 || !m[(s > 0) ? s - 1 : 0])) begin
        e = s;
        while (e + 1 < NT && m[e + 1]) e++;
        if (e - s + 1 > bl) begin bl = e - s + 1; bs = s; end
      end
    end
    ef = (bl < ME);
    c  = ef ? '0 : TW'(bs + (bl - 1) / 2);
  endfunction

  function automatic logic [NT-1:0] rmask();
    logic [NT-1:0] m;
    int k, s, len;
    case ($urandom_range(0, 2))
      0: m = $urandom;
      1: begin
        m = '0;
        k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) begin
          s = $urandom_range(0, NT - 1);
          len = $urandom_range(1, 12);
          for (int j = s; j < s + len && j < NT; j++) m[j] = 1'b1;
        end
      end
      default: m = ($urandom_range(0, 1) != 0) ? '1 : '0;
    endcase
    return m;
  endfunction

  task automatic launch();
    res_t r;
    ld_t e;
    logic [TW-1:0] c;
    logic ef;
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      ref_lane(mask[l], c, ef);
      for (int t = 0; t < NT; t++) begin
        e.ld = NL'(1) << l; e.wd = TW'(t); ld_q.push_back(e);
      end
      e.ld = NL'(1) << l; e.wd = c; ld_q.push_back(e);
      r.tap[l*TW +: TW] = c;
      r.fail[l] = ef || (rb_off[l] != '0);
    end
    exp_q.push_back(r);
    cal_start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    cal_start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done_clr", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input bit spam);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (done) begin cal_start = 1'b0; seen = 1'b1; break; end
      cal_start = spam && ($urandom_range(0, 149) == 0);
    end
    cal_start = 1'b0;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got cal_done=0 want 1 within %0d cycles", LAT + 20);
    end
    @(negedge clk);
    chk("done_held", 64'(done), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_ld"}, 64'(ld), 64'd0);
    chk({tag, "_fail"}, 64'(fail), 64'd0);
    chk({tag, "_lane_tap"}, 64'(lane_tap), 64'd0);
  endtask

  initial begin
    for (int l = 0; l < NL; l++) begin
      mask[l] = '0; cur_tap[l] = '0; rb_off[l] = '0;
    end
    mask[0] = 32'h000F_FC00;               // taps 10..19
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Abort mid-CHECK of lane 1, after lane 0 has already latched its tap.
    launch();
    repeat (462) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    ld_q.delete();
    repeat (2) @(negedge clk);
    chk_zero("midrun_reset");
    rst_n = 1'b1;

    // Directed eyes.
    mask[1] = 32'h0000_00E0;               // 5..7, too narrow
    mask[2] = 32'h00FF_0000;               // readback off by one
    rb_off[2] = 5'd1;
    mask[3] = '1;                          // every tap passes
    mask[4] = rmask(); mask[6] = rmask(); mask[7] = rmask();
    mask[5] = 32'h0FF0_0078;               // 3..6 and 20..27
    launch();
    wait_done(1'b0);

    // Equal eyes, plus start pulses while busy.
    rb_off[2] = '0;
    mask[5] = 32'h00F0_003C;               // 2..5 and 20..23
    launch();
    wait_done(1'b1);

    // Randomised lanes, restarted straight from DONE.
    for (int run = 0; run < 4; run++) begin
      for (int l = 0; l < NL; l++) begin
        mask[l] = rmask();
        rb_off[l] = ($urandom_range(0, 7) == 0) ? TW'($urandom_range(1, NT - 1)) : '0;
      end
      launch();
      wait_done(run[0]);
    end

    repeat (5) @(negedge clk);
    chk("loads_drained", 64'(ld_q.size()), 64'd0);
    chk("results_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_idelay_calib.md
Name: adc_idelay_calib

Overview:
- Per-lane IDELAY tap calibration engine for the LVDS ADC capture path, clocked by the ADC DCO domain.
- With the ADC in a fixed test-pattern mode, it works through the lanes one at a time. For each lane it sweeps every tap, checks the IDDR rising/falling samples against the expected pattern, finds the widest contiguous passing eye and loads its centre tap.
- It then reads the tap back to confirm the load.
- It replaces the fixed IDELAY_VALUE(0) capture with a runtime-calibrated, NUM_LANES-generic capture.

Parameters:
- NUM_LANES, 8, number of ADC data lanes.
- TAP_W, 5, IDELAY tap-value width.
- NUM_TAPS, 32, taps swept, 0..NUM_TAPS-1 (≤ 2**TAP_W).
- SETTLE_CYC, 16, cycles waited after each tap load.
- WINDOW_CYC, 256, compare cycles per tap.
- MIN_EYE, 4, minimum eye width in taps for a lane to pass.
- PATTERN_P, 8'h55, expected rising-edge bit per lane (NUM_LANES bits).
- PATTERN_N, 8'hAA, expected falling-edge bit per lane (NUM_LANES bits).

Ports:
- adc_dco_clk  in  1  ADC DCO clock (BUFR output); sole clock.
- adc_rst_n  in  1  synchronous active-low reset.
- cal_start  in  1  one-cycle start pulse.
- adc_data_p_s  in  NUM_LANES  IDDR Q1 (rising-edge) samples.
- adc_data_n_s  in  NUM_LANES  IDDR Q2 (falling-edge) samples.
- delay_rdata  in  NUM_LANES*TAP_W  IDELAY CNTVALUEOUT, lane l at [l*TAP_W +: TAP_W].
- delay_ld  out  NUM_LANES  one-hot IDELAY load strobe.
- delay_wdata  out  TAP_W  shared IDELAY CNTVALUEIN.
- cal_busy  out  1  high while calibration runs.
- cal_done  out  1  high after completion, held until the next start or reset.
- cal_fail  out  NUM_LANES  per-lane failure flag.
- lane_tap  out  NUM_LANES*TAP_W  final tap per lane.

Behaviour:
- Single clock adc_dco_clk. Reset is synchronous, active-low on adc_rst_n.
- Reset values: all outputs 0; FSM in IDLE. Reset mid-run aborts immediately with delay_ld=0. The block does not restore IDELAY taps; they keep their last loaded value.
- Timing: delay_ld is high for exactly 1 cycle per load, with delay_wdata valid in the same cycle.
- FSM states: IDLE, LOAD, SETTLE, CHECK, EVAL, CENTER, VERIFY, NEXT_LANE, DONE.
- IDLE/DONE: on cal_start, clear cal_done, cal_fail, lane_tap; set lane=0, tap=0, run=0, best_len=0, best_start=0; assert cal_busy; go to LOAD.
- LOAD (1 cycle): delay_ld[lane]=1, delay_wdata=tap; go to SETTLE.
- SETTLE: SETTLE_CYC cycles, then CHECK. During CENTER-driven settling, go to VERIFY instead.
- CHECK: WINDOW_CYC cycles. A sticky err flag sets if adc_data_p_s[lane]!=PATTERN_P[lane] or adc_data_n_s[lane]!=PATTERN_N[lane] on any cycle. Then go to EVAL.
- EVAL (1 cycle):
  - pass (err=0): run=run+1; if run+1 > best_len (strict), then best_len=run+1 and best_start=tap-run.
  - fail: run=0.
  - Clear err. If tap==NUM_TAPS-1 go to CENTER, else tap++ and go to LOAD.
- Tie rule: the lowest-tap eye wins equal widths.
- No wrap: tap NUM_TAPS-1 and tap 0 are never contiguous.
- CENTER:
  - if best_len>=MIN_EYE: ctr = best_start + ((best_len-1)>>1).
  - else: ctr=0 and cal_fail[lane]=1.
  - lane_tap[lane]=ctr. Load ctr (1-cycle delay_ld), then SETTLE.
- VERIFY (1 cycle): if delay_rdata[lane]!=ctr, set cal_fail[lane]=1. Go to NEXT_LANE.
- NEXT_LANE: reset tap, run, best_len, best_start. If lane==NUM_LANES-1 go to DONE, else lane++ and go to LOAD.
- DONE: cal_busy=0, cal_done=1.
- cal_start while cal_busy is ignored. cal_start in DONE restarts calibration.
- Widths: run and best_len are TAP_W+1 bits, so width NUM_TAPS is representable. The window counter is clog2(WINDOW_CYC+1) bits and the settle counter clog2(SETTLE_CYC+1) bits.
- Latency:
  - per tap: SETTLE_CYC+WINDOW_CYC+2 cycles.
  - per lane: NUM_TAPS*(SETTLE_CYC+WINDOW_CYC+2) + SETTLE_CYC + 3 cycles.

Decomposition:
- Shared package adc_if_pkg: TAP_W and NUM_TAPS defaults, the calibration state enum, default PATTERN_P/PATTERN_N constants.
- One sub-module, adc_eye_tracker: run/best_len/best_start bookkeeping plus centre computation. Inputs: clear, eval strobe, pass, tap. Outputs: best_len, ctr.
- The top holds the FSM, counters and lane mux.

Test Plan:
- Reset: drive adc_rst_n=0 for 2 cycles mid-CHECK -> next cycle cal_busy=0, cal_done=0, delay_ld=0, cal_fail=0, lane_tap=0. A subsequent cal_start runs a full calibration normally.
- Single eye: bench IDELAY model where lane 0 passes taps 10..19 -> lane_tap[0]=14, cal_fail[0]=0. Final load shows delay_wdata=14 with delay_ld=8'h01.
- All pass: every tap passes on lane 3 -> best_len=32, lane_tap[3]=15.
- Two eyes: lane 5 passes 3..6 and 20..27 -> lane_tap[5]=23. Equal eyes 2..5 and 20..23 -> lane_tap=3 (first wins).
- Narrow eye: lane 1 passes only 5..7 (MIN_EYE=4) -> cal_fail[1]=1, lane_tap[1]=0, tap 0 loaded. Other lanes are unaffected.
- Readback: model returns delay_rdata lane 2 = ctr+1 -> cal_fail[2]=1.
- Overall: cal_done rises exactly 8*(32*274+19) cycles after cal_start with default parameters. cal_start during busy changes nothing.
